pcie_msi_irq_ctrl: RTL and testbench

//  Converts per-source interrupt request pulses from fpga_core logic into single-shot MSI requests on the

---
 rtl/pcie_msi_irq_ctrl.sv | 219 +++++++++++++++++++++
 tb/tb_pcie_msi_irq_ctrl.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pcie_msi_irq_ctrl.sv
// Converts per-source interrupt pulses into single-shot MSI requests with coalescing, round-robin
// arbitration and retry/drop. Optional MSI_IRQ_STATS_EN adds saturating event counters.
module pcie_msi_irq_ctrl #(
  parameter int unsigned NUM_VEC   = 32,
  parameter int unsigned MAX_RETRY = 3,
  parameter int unsigned TIMEOUT   = 1023
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_VEC-1:0] irq_req,
  output logic               irq_drop,
  output logic [4:0]         irq_drop_vec,
  input  logic               msi_enable,
  input  logic [2:0]         msi_mmenable,
  output logic [31:0]        cfg_interrupt_msi_int,
  input  logic               cfg_interrupt_msi_sent,
  input  logic               cfg_interrupt_msi_fail,
  output logic [3:0]         cfg_interrupt_msi_select,
  output logic [3:0]         cfg_interrupt_msi_function_number,
  output logic [31:0]        cfg_interrupt_msi_pending_status,
  output logic               cfg_interrupt_msi_pending_status_data_enable,
  output logic [2:0]         cfg_interrupt_msi_attr,
  output logic               cfg_interrupt_msi_tph_present,
  output logic [1:0]         cfg_interrupt_msi_tph_type,
  output logic [8:0]         cfg_interrupt_msi_tph_st_tag
`ifdef MSI_IRQ_STATS_EN
  ,
  output logic [31:0]        stat_sent,
  output logic [31:0]        stat_fail,
  output logic [31:0]        stat_drop
`endif
);

  localparam int unsigned IW = (NUM_VEC > 1) ? $clog2(NUM_VEC) : 1;
  localparam int unsigned TW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StIssue = 2'd1;
  localparam logic [1:0] StWait  = 2'd2;
  localparam logic [1:0] StGap   = 2'd3;

  logic [1:0]         state_q, state_d;
  logic [4:0]         vec_q, vec_d;
  logic [4:0]         rr_q, rr_d;
  logic [3:0]         retry_q, retry_d;
  logic [TW-1:0]      timer_q, timer_d;
  logic [NUM_VEC-1:0] pending_q, pending_d;
  logic [31:0]        status_q, status_d;
  logic               drop_q, drop_d;
  logic [4:0]         drop_vec_q, drop_vec_d;

  logic [2:0]         mm_eff;
  logic [4:0]         vec_mask;
  logic [4:0]         v_eff;
  logic               arb_found;
  logic [4:0]         arb_vec;
  logic [4:0]         arb_next;
  logic               do_clear;
  logic               do_abort;
  logic               timed_out;
  int                 idx;

  assign mm_eff    = (msi_mmenable > 3'd5) ? 3'd5 : msi_mmenable;
  assign vec_mask  = 5'((6'd1 << mm_eff) - 6'd1);
  assign v_eff     = vec_q & vec_mask;
  assign timed_out = (timer_q == TW'(TIMEOUT));

  // Lowest pending source at or after rr_q, wrapping at NUM_VEC.
  always_comb begin
    arb_found = 1'b0;
    arb_vec   = 5'd0;
    idx       = 0;
    for (int k = 0; k < int'(NUM_VEC); k++) begin
      idx = int'(rr_q) + k;
      if (idx >= int'(NUM_VEC)) idx = idx - int'(NUM_VEC);
      if (!arb_found && pending_q[IW'(idx)]) begin
        arb_found = 1'b1;
        arb_vec   = 5'(idx);
      end
    end
    arb_next = ((int'(arb_vec) + 1) >= int'(NUM_VEC)) ? 5'd0 : arb_vec + 5'd1;
  end

  always_comb begin
    state_d    = state_q;
    vec_d      = vec_q;
    rr_d       = rr_q;
    retry_d    = retry_q;
    timer_d    = timer_q;
    drop_d     = 1'b0;
    drop_vec_d = drop_vec_q;
    do_clear   = 1'b0;
    do_abort   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (msi_enable && arb_found) begin
          vec_d    = arb_vec;
          rr_d     = arb_next;
          do_clear = 1'b1;
          state_d  = StIssue;
        end
      end
      StIssue: begin
        timer_d = '0;
        state_d = StWait;
      end
      StWait: begin
        if (!msi_enable) begin
          do_abort = 1'b1;
          retry_d  = 4'd0;
          state_d  = StIdle;
        end else if (cfg_interrupt_msi_sent) begin
          retry_d = 4'd0;
          state_d = StIdle;
        end else if (cfg_interrupt_msi_fail || timed_out) begin
          if (retry_q < 4'(MAX_RETRY)) begin
            retry_d = retry_q + 4'd1;
            state_d = StGap;
          end else begin
            drop_d     = 1'b1;
            drop_vec_d = vec_q;
            retry_d    = 4'd0;
            state_d    = StIdle;
          end
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      StGap: begin
        if (!msi_enable) begin
          do_abort = 1'b1;
          retry_d  = 4'd0;
          state_d  = StIdle;
        end else begin
          state_d = StIssue;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // New requests are OR-ed in last so a request coinciding with the arbitration clear survives.
  always_comb begin
    pending_d = pending_q;
    if (do_clear) pending_d[IW'(arb_vec)] = 1'b0;
    if (do_abort) pending_d[IW'(vec_q)] = 1'b1;
    pending_d = pending_d | irq_req;
  end

  always_comb begin
    status_d = 32'd0;
    for (int i = 0; i < int'(NUM_VEC); i++) begin
      if (pending_q[i]) status_d[5'(i) & vec_mask] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      vec_q      <= 5'd0;
      rr_q       <= 5'd0;
      retry_q    <= 4'd0;
      timer_q    <= '0;
      pending_q  <= '0;
      status_q   <= 32'd0;
      drop_q     <= 1'b0;
      drop_vec_q <= 5'd0;
    end else begin
      state_q    <= state_d;
      vec_q      <= vec_d;
      rr_q       <= rr_d;
      retry_q    <= retry_d;
      timer_q    <= timer_d;
      pending_q  <= pending_d;
      status_q   <= status_d;
      drop_q     <= drop_d;
      drop_vec_q <= drop_vec_d;
    end
  end

  assign cfg_interrupt_msi_int = (state_q == StIssue) ? (32'd1 << v_eff) : 32'd0;
  assign irq_drop              = drop_q;
  assign irq_drop_vec          = drop_vec_q;
  assign cfg_interrupt_msi_pending_status             = status_q;
  assign cfg_interrupt_msi_select                     = 4'd0;
  assign cfg_interrupt_msi_function_number            = 4'd0;
  assign cfg_interrupt_msi_pending_status_data_enable = 1'b0;
  assign cfg_interrupt_msi_attr                       = 3'd0;
  assign cfg_interrupt_msi_tph_present                = 1'b0;
  assign cfg_interrupt_msi_tph_type                   = 2'd0;
  assign cfg_interrupt_msi_tph_st_tag                 = 9'd0;

`ifdef MSI_IRQ_STATS_EN
  logic        ev_sent;
  logic        ev_fail;
  logic [31:0] stat_sent_q, stat_fail_q, stat_drop_q;

  assign ev_sent = (state_q == StWait) && msi_enable && cfg_interrupt_msi_sent;
  assign ev_fail = (state_q == StWait) && msi_enable && !cfg_interrupt_msi_sent &&
                   (cfg_interrupt_msi_fail || timed_out);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_sent_q <= 32'd0;
      stat_fail_q <= 32'd0;
      stat_drop_q <= 32'd0;
    end else begin
      if (ev_sent && (stat_sent_q != '1)) stat_sent_q <= stat_sent_q + 32'd1;
      if (ev_fail && (stat_fail_q != '1)) stat_fail_q <= stat_fail_q + 32'd1;
      if (drop_d && (stat_drop_q != '1)) stat_drop_q <= stat_drop_q + 32'd1;
    end
  end

  assign stat_sent = stat_sent_q;
  assign stat_fail = stat_fail_q;
  assign stat_drop = stat_drop_q;
`endif

endmodule

// File: tb/tb_pcie_msi_irq_ctrl.sv
// Directed self-checking bench for pcie_msi_irq_ctrl (TIMEOUT shortened to 20).
module tb_pcie_msi_irq_ctrl;
  localparam int unsigned NV = 32;
  localparam int unsigned MR = 3;
  localparam int unsigned TO = 20;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [31:0] irq_req = '0;
  logic        irq_drop;
  logic [4:0]  irq_drop_vec;
  logic        msi_enable = 1'b1;
  logic [2:0]  msi_mmenable = 3'd5;
  logic [31:0] msi_int;
  logic        sent = 1'b0;
  logic        fail = 1'b0;
  logic [3:0]  msi_select;
  logic [3:0]  fn_num;
  logic [31:0] pend_status;
  logic        pend_de;
  logic [2:0]  attr;
  logic        tph_present;
  logic [1:0]  tph_type;
  logic [8:0]  tph_st_tag;

  int checks = 0;
  int passes = 0;

  pcie_msi_irq_ctrl #(.NUM_VEC(NV), .MAX_RETRY(MR), .TIMEOUT(TO)) dut (
    .clk                                          (clk),
    .rst_n                                        (rst_n),
    .irq_req                                      (irq_req),
    .irq_drop                                     (irq_drop),
    .irq_drop_vec                                 (irq_drop_vec),
    .msi_enable                                   (msi_enable),
    .msi_mmenable                                 (msi_mmenable),
    .cfg_interrupt_msi_int                        (msi_int),
    .cfg_interrupt_msi_sent                       (sent),
    .cfg_interrupt_msi_fail                       (fail),
    .cfg_interrupt_msi_select                     (msi_select),
    .cfg_interrupt_msi_function_number            (fn_num),
    .cfg_interrupt_msi_pending_status             (pend_status),
    .cfg_interrupt_msi_pending_status_data_enable (pend_de),
    .cfg_interrupt_msi_attr                       (attr),
    .cfg_interrupt_msi_tph_present                (tph_present),
    .cfg_interrupt_msi_tph_type                   (tph_type),
    .cfg_interrupt_msi_tph_st_tag                 (tph_st_tag)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_req(input logic [31:0] m);
    irq_req = m;
    step();
    irq_req = '0;
  endtask

  task automatic wait_int(input int budget, output logic [31:0] val, output int cycles);
    cycles = 0;
    val = msi_int;
    while (val == 32'd0 && cycles < budget) begin
      step();
      cycles++;
      val = msi_int;
    end
  endtask

  // Called during the ISSUE cycle: answer with sent on the first WAIT cycle.
  task automatic ack_sent();
    step();
    sent = 1'b1;
    step();
    sent = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    irq_req = '0;
    sent = 1'b0;
    fail = 1'b0;
    msi_enable = 1'b1;
    msi_mmenable = 3'd5;
    step();
    step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_reset();
    #3 rst_n = 1'b0;
    step();
    checks++; if (msi_int !== 32'd0) $display("FAIL reset_int: got %h want 0", msi_int); else passes++;
    checks++; if (irq_drop !== 1'b0 || irq_drop_vec !== 5'd0)
      $display("FAIL reset_drop: got %b/%0d want 0/0", irq_drop, irq_drop_vec); else passes++;
    checks++; if (pend_status !== 32'd0)
      $display("FAIL reset_pending: got %h want 0", pend_status); else passes++;
    checks++; if ({msi_select, fn_num, pend_de, attr, tph_present, tph_type, tph_st_tag} !== 24'd0)
      $display("FAIL const_outputs: got %h want 0",
               {msi_select, fn_num, pend_de, attr, tph_present, tph_type, tph_st_tag});
    else passes++;
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_single();
    logic [31:0] v;
    int c;
    do_reset();
    pulse_req(32'h8);
    checks++; if (msi_int !== 32'd0) $display("FAIL single_early: got %h want 0", msi_int); else passes++;
    step();
    checks++; if (msi_int !== 32'h8) $display("FAIL single_int: got %h want 8", msi_int); else passes++;
    checks++; if (pend_status !== 32'h8)
      $display("FAIL single_status: got %h want 8", pend_status); else passes++;
    step();
    checks++; if (msi_int !== 32'd0) $display("FAIL single_width: got %h want 0", msi_int); else passes++;
    sent = 1'b1;
    step();
    sent = 1'b0;
    checks++; if (pend_status !== 32'd0)
      $display("FAIL single_status_clr: got %h want 0", pend_status); else passes++;
    wait_int(10, v, c);
    checks++; if (v !== 32'd0) $display("FAIL single_extra: got %h want 0", v); else passes++;
  endtask

  task automatic test_coalesce_rr();
    logic [31:0] seq [3];
    logic [31:0] v;
    int c;
    int n;
    do_reset();
    msi_enable = 1'b0;
    pulse_req(32'h1);
    pulse_req(32'h1);
    pulse_req(32'h20);
    step();
    step();
    checks++; if (msi_int !== 32'd0) $display("FAIL coal_disabled: got %h want 0", msi_int); else passes++;
    checks++; if (pend_status !== 32'h21)
      $display("FAIL coal_status: got %h want 21", pend_status); else passes++;
    msi_enable = 1'b1;
    n = 0;
    for (int k = 0; k < 3; k++) begin
      seq[k] = 32'd0;
      wait_int(10, v, c);
      if (v != 32'd0) begin
        seq[n] = v;
        n++;
        ack_sent();
      end
    end
    checks++; if (n !== 2) $display("FAIL coal_count: got %0d want 2", n); else passes++;
    checks++; if (seq[0] !== 32'h1) $display("FAIL coal_first: got %h want 1", seq[0]); else passes++;
    checks++; if (seq[1] !== 32'h20) $display("FAIL coal_second: got %h want 20", seq[1]); else passes++;
  endtask

  task automatic test_remap();
    logic [31:0] v;
    int c;
    do_reset();
    msi_mmenable = 3'd2;
    msi_enable = 1'b0;
    pulse_req(32'h40);
    step();
    step();
    checks++; if (pend_status !== 32'h4)
      $display("FAIL remap_status: got %h want 4", pend_status); else passes++;
    msi_enable = 1'b1;
    wait_int(10, v, c);
    checks++; if (v !== 32'h4) $display("FAIL remap_int: got %h want 4", v); else passes++;
    ack_sent();
    msi_mmenable = 3'd5;
  endtask

  task automatic test_retry_drop();
    logic [31:0] v;
    int c;
    do_reset();
    pulse_req(32'h200);
    for (int p = 0; p < 4; p++) begin
      wait_int(10, v, c);
      checks++; if (v !== 32'h200) $display("FAIL retry_int%0d: got %h want 200", p, v); else passes++;
      if (p > 0) begin
        checks++; if (c !== 1) $display("FAIL retry_gap%0d: got %0d want 1", p, c); else passes++;
      end
      step();
      checks++; if (irq_drop !== 1'b0) $display("FAIL retry_early_drop%0d: got 1 want 0", p); else passes++;
      fail = 1'b1;
      step();
      fail = 1'b0;
    end
    checks++; if (irq_drop !== 1'b1) $display("FAIL drop_pulse: got %b want 1", irq_drop); else passes++;
    checks++; if (irq_drop_vec !== 5'd9)
      $display("FAIL drop_vec: got %0d want 9", irq_drop_vec); else passes++;
    step();
    checks++; if (irq_drop !== 1'b0) $display("FAIL drop_width: got %b want 0", irq_drop); else passes++;
    wait_int(10, v, c);
    checks++; if (v !== 32'd0) $display("FAIL drop_fifth: got %h want 0", v); else passes++;
  endtask

  task automatic test_timeout();
    logic [31:0] v;
    int c;
    do_reset();
    pulse_req(32'h4);
    wait_int(10, v, c);
    checks++; if (v !== 32'h4) $display("FAIL tmo_first: got %h want 4", v); else passes++;
    step();
    wait_int(60, v, c);
    checks++; if (v !== 32'h4) $display("FAIL tmo_reissue: got %h want 4", v); else passes++;
    checks++; if (c !== int'(TO) + 2) $display("FAIL tmo_cycles: got %0d want %0d", c, TO + 2); else passes++;
    ack_sent();
  endtask

  task automatic test_enable_drop();
    logic [31:0] v;
    int c;
    do_reset();
    pulse_req(32'h80);
    wait_int(10, v, c);
    step();
    msi_enable = 1'b0;
    step();
    checks++; if (irq_drop !== 1'b0) $display("FAIL en_no_drop: got %b want 0", irq_drop); else passes++;
    step();
    checks++; if (pend_status !== 32'h80)
      $display("FAIL en_pending: got %h want 80", pend_status); else passes++;
    repeat (3) step();
    checks++; if (msi_int !== 32'd0) $display("FAIL en_held: got %h want 0", msi_int); else passes++;
    msi_enable = 1'b1;
    wait_int(10, v, c);
    checks++; if (v !== 32'h80) $display("FAIL en_reissue: got %h want 80", v); else passes++;
    ack_sent();
    step();
    checks++; if (pend_status !== 32'd0)
      $display("FAIL en_status_clr: got %h want 0", pend_status); else passes++;
  endtask

  task automatic test_back_to_back();
    logic [31:0] v;
    int c;
    do_reset();
    pulse_req(32'h10);
    wait_int(10, v, c);
    step();
    irq_req = 32'h10;
    sent = 1'b1;
    step();
    irq_req = '0;
    sent = 1'b0;
    wait_int(10, v, c);
    checks++; if (v !== 32'h10) $display("FAIL rereq_int: got %h want 10", v); else passes++;
    checks++; if (c !== 1) $display("FAIL rereq_gap: got %0d want 1", c); else passes++;
    step();
    sent = 1'b1;
    fail = 1'b1;
    step();
    sent = 1'b0;
    fail = 1'b0;
    wait_int(10, v, c);
    checks++; if (v !== 32'd0) $display("FAIL sent_wins: got %h want 0", v); else passes++;
  endtask

  task automatic test_reset_mid_wait();
    logic [31:0] v;
    int c;
    do_reset();
    msi_enable = 1'b0;
    pulse_req(32'h1002);
    msi_enable = 1'b1;
    wait_int(10, v, c);
    checks++; if (v !== 32'h2) $display("FAIL mid_first: got %h want 2", v); else passes++;
    step();
    #2 rst_n = 1'b0;
    #1;
    checks++; if (pend_status !== 32'd0)
      $display("FAIL mid_status: got %h want 0", pend_status); else passes++;
    step();
    rst_n = 1'b1;
    wait_int(10, v, c);
    checks++; if (v !== 32'd0) $display("FAIL mid_lost: got %h want 0", v); else passes++;
  endtask

  initial begin
    test_reset();
    test_single();
    test_coalesce_rr();
    test_remap();
    test_retry_drop();
    test_timeout();
    test_enable_drop();
    test_back_to_back();
    test_reset_mid_wait();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
